// File: rtl/instr_encode_loader_if.sv
`default_nettype none
// ============================================================================
// Module : instr_encode_loader_if
// Descriptor-in / imem-write-out bundle for the instruction encode loader.
// Rev    : 1.0
// ============================================================================
interface instr_encode_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct,
               in_imm, in_target, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata, count, full, err
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct,
               in_imm, in_target, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata, count, full, err
    );
endinterface
`default_nettype wire

// File: rtl/instr_encode_loader.sv
`default_nettype none
// ============================================================================
// Module : instr_encode_loader
// Encodes per-field instruction descriptors into MIPS words and streams them
// sequentially into instruction memory.
// Rev    : 1.0
// ============================================================================
module instr_encode_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    instr_encode_loader_if.slave bus
);
    localparam logic [ADDR_W-1:0] c_BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   c_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   c_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    localparam logic [2:0] c_K_R    = 3'd0;
    localparam logic [2:0] c_K_ADDI = 3'd1;
    localparam logic [2:0] c_K_ORI  = 3'd2;
    localparam logic [2:0] c_K_LW   = 3'd3;
    localparam logic [2:0] c_K_SW   = 3'd4;
    localparam logic [2:0] c_K_BEQ  = 3'd5;
    localparam logic [2:0] c_K_J    = 3'd6;
    localparam logic [2:0] c_K_ILL  = 3'd7;

    localparam logic [5:0] c_OP_R    = 6'd0;
    localparam logic [5:0] c_OP_ADDI = 6'd8;
    localparam logic [5:0] c_OP_ORI  = 6'd13;
    localparam logic [5:0] c_OP_LW   = 6'd35;
    localparam logic [5:0] c_OP_SW   = 6'd43;
    localparam logic [5:0] c_OP_BEQ  = 6'd4;
    localparam logic [5:0] c_OP_J    = 6'd2;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_count;
    logic              r_err;

    logic              w_full;
    logic              w_ready;
    logic              w_accept;
    logic              w_legal;
    logic [31:0]       w_enc;

    assign w_full   = (r_count == c_DEPTH);
    assign w_ready  = !rst && !clr && !w_full && (!r_we || bus.imem_ready);
    assign w_accept = bus.in_valid && w_ready;
    assign w_legal  = (bus.in_kind != c_K_ILL);

    assign bus.in_ready   = w_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.count      = r_count;
    assign bus.full       = w_full;
    assign bus.err        = r_err;

    always_comb begin
        w_enc = 32'd0;
        case (bus.in_kind)
            c_K_R:    w_enc = {c_OP_R, bus.in_rs, bus.in_rt, bus.in_rd,
                               bus.in_shamt, bus.in_funct};
            c_K_ADDI: w_enc = {c_OP_ADDI, bus.in_rs, bus.in_rt, bus.in_imm};
            c_K_ORI:  w_enc = {c_OP_ORI,  bus.in_rs, bus.in_rt, bus.in_imm};
            c_K_LW:   w_enc = {c_OP_LW,   bus.in_rs, bus.in_rt, bus.in_imm};
            c_K_SW:   w_enc = {c_OP_SW,   bus.in_rs, bus.in_rt, bus.in_imm};
            c_K_BEQ:  w_enc = {c_OP_BEQ,  bus.in_rs, bus.in_rt, bus.in_imm};
            c_K_J:    w_enc = {c_OP_J, bus.in_target};
            default:  w_enc = 32'd0;
        endcase
    end

    // A new legal accept always reloads the output register; a completed
    // write with nothing behind it simply drops imem_we.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_we    <= 1'b0;
            r_addr  <= c_BASE;
            r_wdata <= 32'd0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept && w_legal) begin
                r_we    <= 1'b1;
                r_addr  <= c_BASE + r_count[ADDR_W-1:0];
                r_wdata <= w_enc;
                r_count <= r_count + c_ONE;
            end else if (r_we && bus.imem_ready) begin
                r_we    <= 1'b0;
            end
            if (w_accept && !w_legal) begin
                r_err   <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Encoder side of the control-decode path: converts per-field instruction descriptors into 32-bit MIPS words and writes them sequentially into instruction memory.
- Used by the bench/boot loader to fill imem before the single-cycle core runs.
- Covers the opcodes the core's decoder supports: R-type (0), addi (8), ori (13), lw (35), sw (43), beq (4) and j (2).
- One-entry output register with valid/ready on both sides; sticky error on illegal kinds; fill counter with full detection.

Parameters:
- ADDR_W, 8, imem word-address width; capacity DEPTH = 2**ADDR_W words.
- BASE_ADDR, 0, first word address written after reset/clr. Addresses are BASE_ADDR + index, modulo 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- clr  in  1  synchronous restart pulse: same effect as rst.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  descriptor accepted when in_valid & in_ready at rising edge.
- in_kind  in  3  0=R, 1=ADDI, 2=ORI, 3=LW, 4=SW, 5=BEQ, 6=J, 7=illegal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields.
- in_funct  in  6  R-type function field.
- in_imm  in  16  immediate/offset.
- in_target  in  26  jump target field.
- imem_we  out  1  write request valid.
- imem_ready  in  1  memory accepts write when imem_we & imem_ready at edge.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  legal descriptors accepted since reset/clr, including the pending one.
- full  out  1  count == DEPTH.
- err  out  1  sticky: an illegal kind was accepted.

Behaviour:
- Reset (rst or clr): imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, full=0, err=0. Any pending write is dropped.
- in_ready = !rst & !clr & !full & (!imem_we | imem_ready). This is combinational, so writes can stream back-to-back.
- Encoding, registered on accept; one-cycle latency to imem_we:
  - R: {6'd0, rs, rt, rd, shamt, funct}.
  - ADDI/ORI/LW/SW/BEQ: {op, rs, rt, imm}, with op = 8/13/35/43/4 respectively.
  - J: {6'd2, target}.
  - Unused fields are ignored.
- Legal accept:
  - imem_we=1 next cycle.
  - imem_addr = (BASE_ADDR + count_before) mod DEPTH.
  - count increments.
- Illegal accept (kind 7):
  - Handshake completes.
  - err set; nothing written; count unchanged.
  - If no other write is being accepted, imem_we falls after the in-flight write completes.
- Hold rule: while imem_we=1 and imem_ready=0, imem_we, imem_addr and imem_wdata are held stable and in_ready=0.
- Completion without a new accept: if imem_we & imem_ready and no new legal accept occurs, imem_we=0 next cycle; addr and wdata may hold their last values.
- Full:
  - When count reaches DEPTH, full=1 and in_ready=0.
  - The final pending write still completes normally.
  - No address wrap ever overwrites a word; only clr/rst restarts filling.
- Simultaneous events:
  - clr with in_valid: clr wins; no accept.
  - clr during a held write: the write is abandoned and imem_we=0 next cycle.
  - rst and clr together are equivalent to rst.
- err and full remain set until rst/clr.

Test Plan:
- R add $3,$1,$2 (kind0, rs=1, rt=2, rd=3, shamt=0, funct=0x20), imem_ready=1 -> next cycle imem_we=1, addr=0, wdata=0x00221820, count=1.
- Stream addi rt=8 imm=5; lw rs=29 rt=9 imm=4; beq rs=1 rt=2 imm=0xFFFF; j target=0x0100000 on consecutive cycles, imem_ready=1:
  - wdata 0x20080005, 0x8FA90004, 0x1022FFFF, 0x08100000 at addr 0..3 on consecutive cycles.
  - in_ready stays 1 throughout.
- Backpressure: imem_ready=0 for 3 cycles with a write pending -> imem_we, addr and wdata stable; in_ready=0; write completes on the cycle imem_ready=1.
- ADDR_W=2, BASE_ADDR=2: four legal accepts -> addrs 2,3,0,1; full=1 after the 4th accept; a 5th in_valid is not accepted.
- kind=7 accepted -> err=1, no imem_we, count unchanged; next legal descriptor is written at the unchanged address.
- clr asserted while a write is held (imem_ready=0) -> imem_we=0, count=0, err=0, full=0 next cycle; next accept writes addr=BASE_ADDR.
